hptdc_readout_fifo: RTL
=======================

HPTDC_READOUT_FIFO -- requirements
Module: hptdc_readout_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, HPTDC word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, FIFO depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter N_CH, default 2, HPTDC channel count; legal values are 1, 2, 3 and 4.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-16, almost-full level.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-007 SHALL have port hptdc_data, input, N_CH*DATA_WIDTH bits; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port hptdc_data_ready, input, N_CH bits, per-channel data-ready level.
REQ-009 SHALL have port hptdc_get_data, output, N_CH bits, per-channel one-cycle capture acknowledge.
REQ-010 SHALL have port read_enable, input, 1 bit, consumer pop request.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits, popped word.
REQ-012 SHALL have port ch_out, output, 2 bits, source channel of data_out.
REQ-013 SHALL have port output_ready, output, 1 bit, one-cycle pulse marking data_out/ch_out valid.
REQ-014 SHALL have ports empty, full and almost_full, each output, 1 bit.
REQ-015 SHALL have port level, output, ADDR_WIDTH+1 bits, stored word count.
REQ-016 SHALL have port drop_count, output, 16 bits, lost-word counter.

Function
REQ-017 SHALL register hptdc_data_ready per channel and detect a rising edge as ready=1 with previous=0.
REQ-018 SHALL, on a rising edge, load that channel's hptdc_data into a one-deep pending register, set its pending flag, and pulse hptdc_get_data[i] high in the next cycle.
REQ-019 SHALL, on a rising edge while the channel's pending flag stays set that cycle, discard the word, not pulse get_data, and increment drop_count.
REQ-020 SHALL grant at most one pending channel per cycle, round-robin from rr_ptr, only while full=0.
REQ-021 SHALL, on a grant, write {channel, pending word} to mem[wr_ptr], increment wr_ptr and clear the pending flag.
REQ-022 SHALL then set rr_ptr to (granted channel+1) mod N_CH.
REQ-023 SHALL, when a channel is granted and captures a new edge in the same cycle, write the old word and hold the new word pending with no drop.
REQ-024 SHALL, on read_enable=1 with empty=0, load data_out and ch_out from mem[rd_ptr] and increment rd_ptr; output_ready pulses 1 the next cycle (one-cycle latency, first-in first-out order).
REQ-025 SHALL ignore read_enable while empty=1: output_ready=0 and data_out holds; an empty FIFO is never bypassed.
REQ-026 SHALL let wr_ptr and rd_ptr wrap from DEPTH-1 to 0.
REQ-027 SHALL update level as +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-028 SHALL block writes while full=1, including in a cycle that also reads; pending words wait and are not dropped.
REQ-029 SHALL drive empty=(level==0), full=(level==DEPTH) and almost_full=(level>=AF_THRESH), all registered and consistent with level.

Reset
REQ-030 SHALL, while rst=0 at a clock edge, clear pointers, level, rr_ptr, pending flags, data_out, ch_out, output_ready, hptdc_get_data and drop_count.
REQ-031 SHALL, during reset, drive empty=1, full=0 and almost_full=0.
REQ-032 SHALL, during reset, load the previous-ready registers with the current hptdc_data_ready, so a level already high at release captures nothing.
REQ-033 SHALL, on reset asserted mid-operation, discard stored and pending words; memory contents are not cleared.

Configuration
REQ-034 SHALL, with macro HPTDC_FIFO_DROP_CNT_EN defined, make drop_count a 16-bit counter that saturates at 16'hFFFF.
REQ-035 SHALL, without HPTDC_FIFO_DROP_CNT_EN, tie drop_count to 0 and synthesise no counter logic; drop behaviour is otherwise identical.

Verification
REQ-036 SHALL cover: N_CH=2, rising edge on ch0 with 32'hA5A5_0001, then read_enable -> get_data[0] pulse, then output_ready=1 with data_out=32'hA5A5_0001, ch_out=0, empty=1.
REQ-037 SHALL cover: both channels edge in the same cycle (0x11, 0x22) with rr_ptr=0 -> written ch0 then ch1; reads return 0x11 then 0x22 with ch_out 0 then 1.
REQ-038 SHALL cover: ADDR_WIDTH=4, 16 writes -> full=1 and level=16; a 17th edge stays pending; then 1 read -> the pending word is written next cycle, level=16, full=1, drop_count=0.
REQ-039 SHALL cover: a second ch0 edge while the ch0 word is pending behind full=1 -> drop_count=1 with the macro defined, 0 without it, and no get_data pulse.
REQ-040 SHALL cover: 40 write/read pairs at ADDR_WIDTH=4 -> pointers wrap, data order preserved, level returns to 0.
REQ-041 SHALL cover: rst=0 for one cycle with level=5 and data_ready high -> level=0, empty=1, no capture until ready falls and rises again.

Source files
------------

// File: rtl/hptdc_readout_fifo.sv
// HPTDC readout FIFO.
// Captures one word per rising edge of each channel's data-ready level into a one-deep
// pending register, arbitrates pending words round-robin into a single FIFO tagged with
// the source channel, and pops them to the consumer with one cycle of read latency.
// Optional feature: define HPTDC_FIFO_DROP_CNT_EN to build the saturating lost-word
// counter; without it drop_count is tied to zero.
module hptdc_readout_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int N_CH       = 2,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*DATA_WIDTH-1:0] hptdc_data,
  input  logic [N_CH-1:0]            hptdc_data_ready,
  output logic [N_CH-1:0]            hptdc_get_data,
  input  logic                       read_enable,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 ch_out,
  output logic                       output_ready,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [ADDR_WIDTH:0]        level,
  output logic [15:0]                drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int MEM_W = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]   LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [2:0]            NCH3     = 3'(N_CH);
  localparam logic [1:0]            LAST_CH  = 2'(N_CH - 1);

  // Channel capture state
  logic [N_CH-1:0]            r_prev_ready;
  logic [N_CH-1:0]            r_pend_vld;
  logic [N_CH*DATA_WIDTH-1:0] r_pend_data;
  logic [N_CH-1:0]            r_get_data;

  // FIFO state
  logic [MEM_W-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [1:0]            r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic [1:0]            r_ch_out;
  logic                  r_output_ready;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almost_full;

  // Combinational signals
  logic [N_CH-1:0]         w_edge;
  logic [N_CH-1:0]         w_keep;
  logic [N_CH-1:0]         w_capture;
  logic [3:0]              w_pend_vld4;
  logic [4*DATA_WIDTH-1:0] w_pend_pad;
  logic                    w_grant_vld;
  logic [1:0]              w_grant_ch;
  logic [N_CH-1:0]         w_grant_oh;
  logic [DATA_WIDTH-1:0]   w_grant_data;
  logic [1:0]              w_rr_nxt;
  logic                    w_wr;
  logic                    w_rd;
  logic [ADDR_WIDTH:0]     w_level_d;

  // Pad pending state to four channels so a 2-bit channel number indexes it directly.
  assign w_pend_vld4 = 4'(r_pend_vld);
  assign w_pend_pad  = (4*DATA_WIDTH)'(r_pend_data);

  assign w_edge = hptdc_data_ready & ~r_prev_ready;

  // Round-robin search for the first pending channel starting at r_rr_ptr; no grant when full
  always_comb begin
    logic [2:0] sum;
    logic [2:0] idx;
    w_grant_vld = 1'b0;
    w_grant_ch  = 2'd0;
    sum         = 3'd0;
    idx         = 3'd0;
    if (!r_full) begin
      for (int k = 0; k < N_CH; k++) begin
        sum = {1'b0, r_rr_ptr} + 3'(k);
        idx = (sum >= NCH3) ? (sum - NCH3) : sum;
        if (!w_grant_vld && w_pend_vld4[idx[1:0]]) begin
          w_grant_vld = 1'b1;
          w_grant_ch  = idx[1:0];
        end
      end
    end
  end

  // One-hot form of the grant for per-channel pending updates
  always_comb begin
    w_grant_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_grant_oh[i] = w_grant_vld && (w_grant_ch == 2'(i));
    end
  end

  assign w_grant_data = w_pend_pad[w_grant_ch*DATA_WIDTH +: DATA_WIDTH];
  assign w_rr_nxt     = (w_grant_ch == LAST_CH) ? 2'd0 : w_grant_ch + 2'd1;

  // A pending word that is not granted this cycle still occupies the slot; a new edge
  // then has nowhere to go and is dropped. A granted slot frees up in time for a new edge.
  assign w_keep    = r_pend_vld & ~w_grant_oh;
  assign w_capture = w_edge & ~w_keep;

  assign w_wr = w_grant_vld;
  assign w_rd = read_enable & ~r_empty;

  // Stored-word count: writes and reads in the same cycle cancel
  always_comb begin
    w_level_d = r_level;
    unique case ({w_wr, w_rd})
      2'b10:   w_level_d = r_level + LVL_ONE;
      2'b01:   w_level_d = r_level - LVL_ONE;
      default: w_level_d = r_level;
    endcase
  end

  // Edge detection, pending flags and capture acknowledge
  always_ff @(posedge clk) begin
    // Previous-ready tracks the input even in reset so a level held high across release
    // is not seen as an edge.
    r_prev_ready <= hptdc_data_ready;
    if (!rst) begin
      r_pend_vld <= '0;
      r_get_data <= '0;
    end else begin
      r_pend_vld <= w_keep | w_capture;
      r_get_data <= w_capture;
    end
  end

  // Pending word storage; only meaningful while its flag is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_capture[i]) begin
        r_pend_data[i*DATA_WIDTH +: DATA_WIDTH] <= hptdc_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FIFO memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (rst && w_wr) begin
      r_mem[r_wr_ptr] <= {w_grant_ch, w_grant_data};
    end
  end

  // Pointers, level, arbitration pointer, read port and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_rr_ptr       <= 2'd0;
      r_data_out     <= '0;
      r_ch_out       <= 2'd0;
      r_output_ready <= 1'b0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_rr_ptr <= w_rr_nxt;
      end
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr][DATA_WIDTH-1:0];
        r_ch_out   <= r_mem[r_rd_ptr][MEM_W-1:DATA_WIDTH];
      end
      r_output_ready <= w_rd;
      r_level        <= w_level_d;
      r_empty        <= (w_level_d == '0);
      r_full         <= (w_level_d == LVL_FULL);
      r_almost_full  <= (int'(w_level_d) >= AF_THRESH);
    end
  end

`ifdef HPTDC_FIFO_DROP_CNT_EN
  logic [N_CH-1:0] w_drop;
  logic [2:0]      w_drop_n;
  logic [16:0]     w_drop_sum;
  logic [15:0]     r_drop_cnt;

  assign w_drop     = w_edge & w_keep;
  assign w_drop_n   = 3'($countones(w_drop));
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);

  // Lost-word counter, saturating at all ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop_sum[16]) begin
      r_drop_cnt <= 16'hFFFF;
    end else begin
      r_drop_cnt <= w_drop_sum[15:0];
    end
  end

  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 16'd0;
`endif

  assign hptdc_get_data = r_get_data;
  assign data_out       = r_data_out;
  assign ch_out         = r_ch_out;
  assign output_ready   = r_output_ready;
  assign empty          = r_empty;
  assign full           = r_full;
  assign almost_full    = r_almost_full;
  assign level          = r_level;

endmodule
